axi4_rb_sched: RTL



---
 rtl/axi4_rb_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/axi4_rb_sched.sv
// Round-robin scheduler between the paired AW/W head and the AR head onto a
// single-port register bank, with one held B and one held R response.
module axi4_rb_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int IDX_WIDTH  = 4,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 15
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    wr_req_valid,
  input  logic [ID_WIDTH-1:0]     wr_req_id,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
  input  logic [DATA_WIDTH-1:0]   wr_req_data,
  input  logic [DATA_WIDTH/8-1:0] wr_req_strb,
  output logic                    wr_req_ready,
  input  logic                    rd_req_valid,
  input  logic [ID_WIDTH-1:0]     rd_req_id,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
  output logic                    rd_req_ready,
  output logic                    bank_en,
  output logic                    bank_we,
  output logic [IDX_WIDTH-1:0]    bank_idx,
  output logic [DATA_WIDTH-1:0]   bank_wdata,
  output logic [DATA_WIDTH/8-1:0] bank_wstrb,
  input  logic [DATA_WIDTH-1:0]   bank_rdata,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [1:0]              b_resp,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [ID_WIDTH-1:0]     r_id,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic [7:0]              err_cnt
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN_A  = ADDR_WIDTH'(END_ADDR - START_ADDR);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WR, RD, RDW} state_t;

  state_t                  state_reg, state_next;
  logic                    last_rd_reg;
  logic [ID_WIDTH-1:0]     req_id_reg;
  logic [IDX_WIDTH-1:0]    req_idx_reg;
  logic [DATA_WIDTH-1:0]   req_wdata_reg;
  logic [STRB_WIDTH-1:0]   req_wstrb_reg;
  logic                    in_range_reg;
  logic                    b_valid_reg, r_valid_reg;
  logic [ID_WIDTH-1:0]     b_id_reg, r_id_reg;
  logic [1:0]              b_resp_reg, r_resp_reg;
  logic [DATA_WIDTH-1:0]   r_data_reg;
  logic [7:0]              err_cnt_reg;

  logic                    wr_elig, rd_elig;
  logic                    grant_wr, grant_rd;
  logic [ADDR_WIDTH-1:0]   sel_addr, sel_offset;
  logic                    sel_in_range;
  logic                    resp_load, decerr_load;

  // Eligibility uses the pre-handshake valid, so a same-channel request waits a cycle.
  always_comb begin
    wr_elig    = wr_req_valid && !b_valid_reg;
    rd_elig    = rd_req_valid && !r_valid_reg;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (wr_elig && (!rd_elig || last_rd_reg)) begin
          grant_wr   = 1'b1;
          state_next = WR;
        end else if (rd_elig) begin
          grant_rd   = 1'b1;
          state_next = RD;
        end
      end
      WR:      state_next = IDLE;
      RD:      state_next = RDW;
      RDW:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Offset compare covers both bounds: addresses below START wrap to a large offset.
  assign sel_addr     = grant_wr ? wr_req_addr : rd_req_addr;
  assign sel_offset   = sel_addr - START_A;
  assign sel_in_range = (sel_offset <= SPAN_A);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg     <= IDLE;
      last_rd_reg   <= 1'b1;
      req_id_reg    <= '0;
      req_idx_reg   <= '0;
      req_wdata_reg <= '0;
      req_wstrb_reg <= '0;
      in_range_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_wr || grant_rd) begin
        last_rd_reg  <= grant_rd;
        req_id_reg   <= grant_wr ? wr_req_id : rd_req_id;
        req_idx_reg  <= sel_offset[IDX_WIDTH-1:0];
        in_range_reg <= sel_in_range;
      end
      if (grant_wr) begin
        req_wdata_reg <= wr_req_data;
        req_wstrb_reg <= wr_req_strb;
      end
    end
  end

  assign resp_load   = (state_reg == WR) || (state_reg == RDW);
  assign decerr_load = resp_load && !in_range_reg;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      b_valid_reg <= 1'b0;
      b_id_reg    <= '0;
      b_resp_reg  <= '0;
      r_valid_reg <= 1'b0;
      r_id_reg    <= '0;
      r_data_reg  <= '0;
      r_resp_reg  <= '0;
      err_cnt_reg <= '0;
    end else begin
      if (state_reg == WR) begin
        b_valid_reg <= 1'b1;
        b_id_reg    <= req_id_reg;
        b_resp_reg  <= in_range_reg ? RESP_OKAY : RESP_DECERR;
      end else if (b_valid_reg && b_ready) begin
        b_valid_reg <= 1'b0;
      end
      if (state_reg == RDW) begin
        r_valid_reg <= 1'b1;
        r_id_reg    <= req_id_reg;
        r_data_reg  <= in_range_reg ? bank_rdata : '0;
        r_resp_reg  <= in_range_reg ? RESP_OKAY : RESP_DECERR;
      end else if (r_valid_reg && r_ready) begin
        r_valid_reg <= 1'b0;
      end
      if (decerr_load && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  // Strobe decodes straight from the state register, so reset drops it at once.
  assign bank_en      = in_range_reg && ((state_reg == WR) || (state_reg == RD));
  assign bank_we      = (state_reg == WR);
  assign bank_idx     = req_idx_reg;
  assign bank_wdata   = req_wdata_reg;
  assign bank_wstrb   = req_wstrb_reg;
  assign wr_req_ready = grant_wr;
  assign rd_req_ready = grant_rd;
  assign b_valid      = b_valid_reg;
  assign b_id         = b_id_reg;
  assign b_resp       = b_resp_reg;
  assign r_valid      = r_valid_reg;
  assign r_id         = r_id_reg;
  assign r_data       = r_data_reg;
  assign r_resp       = r_resp_reg;
  assign err_cnt      = err_cnt_reg;

endmodule
